// File: rtl/hclk_gen.sv
// Divides clk down to the HCLK bus clock and emits one-cycle strobes on each HCLK edge.
// Every high and low phase runs to full length, so starting or stopping never produces a runt pulse.
module hclk_gen #(
    parameter int DIV_W        = 8,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] half_period,
    output logic             HCLK,
    output logic             HCLK_rise,
    output logic             HCLK_fall,
    output logic             running,
    output logic [CNT_W-1:0] hclk_count
);

    // state | meaning
    // IDLE  | HCLK held low, waiting for enable
    // HIGH  | HCLK high phase, counter counts down to 0
    // LOW   | HCLK low phase; at terminal count either rise again or stop
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] half_lat;
    logic [DIV_W-1:0] hp_eff;
    logic [DIV_W-1:0] hp_new;

    // A half-period of 0 behaves like 1, so HCLK always toggles.
    assign hp_eff = (half_lat == '0) ? DIV_W'(1) : half_lat;
    assign hp_new = (half_period == '0) ? DIV_W'(1) : half_period;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            half_lat   <= DIV_W'(DEFAULT_HALF);
            HCLK       <= 1'b0;
            HCLK_rise  <= 1'b0;
            HCLK_fall  <= 1'b0;
            running    <= 1'b0;
            hclk_count <= '0;
        end else begin
            HCLK_rise <= 1'b0;
            HCLK_fall <= 1'b0;
            case (state)
                IDLE: begin
                    HCLK <= 1'b0;
                    if (enable) begin
                        half_lat   <= half_period;
                        cnt        <= hp_new - DIV_W'(1);
                        HCLK       <= 1'b1;
                        HCLK_rise  <= 1'b1;
                        running    <= 1'b1;
                        hclk_count <= hclk_count + CNT_W'(1);
                        state      <= HIGH;
                    end
                end
                HIGH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        cnt       <= hp_eff - DIV_W'(1);
                        HCLK      <= 1'b0;
                        HCLK_fall <= 1'b1;
                        state     <= LOW;
                    end
                end
                LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else if (enable) begin
                        // Back-to-back period: half_period is re-sampled on this rise.
                        half_lat   <= half_period;
                        cnt        <= hp_new - DIV_W'(1);
                        HCLK       <= 1'b1;
                        HCLK_rise  <= 1'b1;
                        hclk_count <= hclk_count + CNT_W'(1);
                        state      <= HIGH;
                    end else begin
                        running <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    HCLK    <= 1'b0;
                    running <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hclk_gen.sv
// Bench for hclk_gen: directed scenarios plus random enable/half_period traffic.
// The reference is a per-cycle waveform queue filled one whole HCLK period at a time.
module tb_hclk_gen;

    logic        clk = 1'b1;
    logic        n_rst;
    logic        enable;
    logic [7:0]  half_period;
    logic        hclk, hclk_rise, hclk_fall, running;
    logic [15:0] hclk_count;
    logic        h4, h4_rise, h4_fall, run4;
    logic [3:0]  count4;

    hclk_gen dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .half_period(half_period),
        .HCLK(hclk), .HCLK_rise(hclk_rise), .HCLK_fall(hclk_fall),
        .running(running), .hclk_count(hclk_count)
    );

    hclk_gen #(.CNT_W(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .enable(enable), .half_period(half_period),
        .HCLK(h4), .HCLK_rise(h4_rise), .HCLK_fall(h4_fall),
        .running(run4), .hclk_count(count4)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic h; logic r; logic f;} ent_t;
    ent_t q[$];
    ent_t cur;
    logic m_run;
    int   m_count;
    int   m_hp;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("hclk", 32'(hclk), 32'(cur.h));
        check("rise", 32'(hclk_rise), 32'(cur.r));
        check("fall", 32'(hclk_fall), 32'(cur.f));
        check("running", 32'(running), 32'(m_run));
        check("count", 32'(hclk_count), 32'(m_count % 65536));
        check("hclk_w4", 32'(h4), 32'(cur.h));
        check("count_w4", 32'(count4), 32'(m_count % 16));
    endtask

    task automatic model_reset();
        q.delete();
        cur     = '0;
        m_run   = 1'b0;
        m_count = 0;
        m_hp    = 0;
    endtask

    // At each edge with no period in flight, an enable starts a whole new period.
    task automatic model_edge();
        int h;
        if (q.size() == 0 && enable) begin
            h = (half_period == 0) ? 1 : int'(half_period);
            m_hp = h;
            for (int i = 0; i < h; i++) q.push_back('{h: 1'b1, r: (i == 0), f: 1'b0});
            for (int i = 0; i < h; i++) q.push_back('{h: 1'b0, r: 1'b0, f: (i == 0)});
            m_count++;
        end
        if (q.size() > 0) begin
            cur   = q.pop_front();
            m_run = 1'b1;
        end else begin
            cur   = '0;
            m_run = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic reset_mid();
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Advance to the second clk cycle of a high phase whose latched half-period is 5.
    task automatic seek_high2_hp5();
        for (int i = 0; i < 40; i++) begin
            step();
            if (cur.r && m_hp == 5) begin
                step();
                return;
            end
        end
        total++;
        bad++;
        $error("FAIL seek_rise observed=timeout expected=rise_with_hp5");
    endtask

    initial begin
        n_rst       = 1'b0;
        enable      = 1'b0;
        half_period = 8'd5;
        model_reset();
        #12;
        check_all();
        #3 n_rst = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // 10 periods at hp=5
        #1 enable = 1'b1;
        for (int i = 0; i < 100; i++) step();
        check("count_after_10", 32'(hclk_count), 32'd10);

        // half_period change two cycles into a high phase
        step();
        step();
        half_period = 8'd2;
        for (int i = 0; i < 30; i++) step();

        // stop request in cycle 2 of a hp=5 high phase
        half_period = 8'd5;
        seek_high2_hp5();
        enable = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("stopped", 32'(running), 32'd0);
        check("stopped_hclk", 32'(hclk), 32'd0);

        // hp=0 and hp=1 toggle every clk; also drives the 4-bit counter through wrap
        enable      = 1'b1;
        half_period = 8'd0;
        for (int i = 0; i < 20; i++) step();
        half_period = 8'd1;
        for (int i = 0; i < 20; i++) step();

        // async reset in the middle of a high phase, then restart at 5/5
        half_period = 8'd5;
        seek_high2_hp5();
        reset_mid();
        for (int i = 0; i < 25; i++) step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) half_period = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) reset_mid();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
